// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with round-robin replacement, whole-block fill and miss counter.
// Hit returns in the same cycle; a miss takes WORDS + iwait stall cycles + 1; iwait stalls the fill word by word.
module icache_assoc #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int WORDS = 2,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    output logic             ihit,
    output logic [31:0]      imemload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] miss_count
);
    localparam int OW  = $clog2(WORDS);
    localparam int IW  = $clog2(SETS);
    localparam int TW  = 30 - OW - IW;
    localparam int OWP = (OW > 0) ? OW : 1;
    localparam int PW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int HCW = $clog2(WAYS + 1);

    typedef enum logic {IDLE, FILL} state_t;
    state_t state;

    logic [SETS-1:0][WAYS-1:0] valid;
    logic [SETS-1:0][PW-1:0]   vptr;
    logic [TW-1:0]             tags [SETS][WAYS];
    logic [31:0]               data [SETS][WAYS][WORDS];
    logic [31:0]               fbuf [WORDS];

    logic [OWP-1:0] wofs, k;
    logic [IW-1:0]  idx, fill_idx;
    logic [TW-1:0]  tag, fill_tag;
    logic [31:0]    blk_base;

    // Zero-width offset collapses to a constant-zero 1-bit field.
    assign wofs     = OWP'((imemaddr >> 2) & 32'(WORDS - 1));
    assign idx      = IW'(imemaddr >> (2 + OW));
    assign tag      = TW'(imemaddr >> (2 + OW + IW));
    assign blk_base = imemaddr & ~32'(4 * WORDS - 1);

    logic           hit_any;
    logic [PW-1:0]  hit_way;
    logic [HCW-1:0] hit_cnt;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        hit_cnt = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[idx][w] && tags[idx][w] == tag) begin
                hit_any = 1'b1;
                hit_way = PW'(w);
                hit_cnt = hit_cnt + HCW'(1);
            end
        end
    end

    assign ihit     = nRST && !flush && (state == IDLE) && imemREN && hit_any;
    assign imemload = data[idx][hit_way][wofs];

    // Lowest free way wins; the round-robin pointer is only consulted when the set is full.
    logic          vic_free;
    logic [PW-1:0] victim;

    always_comb begin
        vic_free = 1'b0;
        victim   = vptr[fill_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid[fill_idx][w]) begin
                vic_free = 1'b1;
                victim   = PW'(w);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST && state == IDLE && imemREN)
            assert (hit_cnt <= HCW'(1));
    end

    always_ff @(posedge CLK) begin
        if (!nRST || flush) begin
            state      <= IDLE;
            valid      <= '0;
            vptr       <= '0;
            miss_count <= '0;
            iREN       <= 1'b0;
            k          <= '0;
            if (!nRST)
                iaddr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (imemREN && !hit_any) begin
                        state    <= FILL;
                        k        <= '0;
                        iREN     <= 1'b1;
                        iaddr    <= blk_base;
                        fill_idx <= idx;
                        fill_tag <= tag;
                        if (miss_count != '1)
                            miss_count <= miss_count + CNT_W'(1);
                    end
                end
                FILL: begin
                    if (!iwait) begin
                        fbuf[k] <= iload;
                        if (32'(k) == WORDS - 1) begin
                            // Final word goes straight from iload into the line.
                            state                   <= IDLE;
                            iREN                    <= 1'b0;
                            valid[fill_idx][victim] <= 1'b1;
                            tags[fill_idx][victim]  <= fill_tag;
                            for (int w = 0; w < WORDS; w++)
                                data[fill_idx][victim][w] <= (w == WORDS - 1) ? iload : fbuf[w];
                            if (!vic_free)
                                vptr[fill_idx] <= PW'((32'(vptr[fill_idx]) + 1) % WAYS);
                        end else begin
                            k     <= k + OWP'(1);
                            iaddr <= iaddr + 32'd4;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboarded bench for icache_assoc across three parameter sets, with a set/way reference model.
module tb_icache_assoc;
    logic CLK = 1'b0;
    logic nRST;
    logic flush;
    always #5 CLK = ~CLK;

    logic        imemREN  [3];
    logic [31:0] imemaddr [3];
    logic        ihit     [3];
    logic [31:0] imemload [3];
    logic        iREN     [3];
    logic [31:0] iaddr    [3];
    logic        iwait    [3];
    logic [31:0] iload    [3];
    logic [15:0] mc0, mc2;
    logic [3:0]  mc1;
    logic [15:0] mc [3];
    assign mc[0] = mc0;
    assign mc[1] = {12'd0, mc1};
    assign mc[2] = mc2;

    icache_assoc #(.SETS(8), .WAYS(2), .WORDS(2), .CNT_W(16)) u_dut0 (
        .CLK(CLK), .nRST(nRST), .flush(flush), .imemREN(imemREN[0]), .imemaddr(imemaddr[0]),
        .ihit(ihit[0]), .imemload(imemload[0]), .iREN(iREN[0]), .iaddr(iaddr[0]),
        .iwait(iwait[0]), .iload(iload[0]), .miss_count(mc0));
    icache_assoc #(.SETS(4), .WAYS(1), .WORDS(1), .CNT_W(4)) u_dut1 (
        .CLK(CLK), .nRST(nRST), .flush(flush), .imemREN(imemREN[1]), .imemaddr(imemaddr[1]),
        .ihit(ihit[1]), .imemload(imemload[1]), .iREN(iREN[1]), .iaddr(iaddr[1]),
        .iwait(iwait[1]), .iload(iload[1]), .miss_count(mc1));
    icache_assoc #(.SETS(2), .WAYS(4), .WORDS(8), .CNT_W(16)) u_dut2 (
        .CLK(CLK), .nRST(nRST), .flush(flush), .imemREN(imemREN[2]), .imemaddr(imemaddr[2]),
        .ihit(ihit[2]), .imemload(imemload[2]), .iREN(iREN[2]), .iaddr(iaddr[2]),
        .iwait(iwait[2]), .iload(iload[2]), .miss_count(mc2));

    int cfg_sets  [3] = '{8, 4, 2};
    int cfg_ways  [3] = '{2, 1, 4};
    int cfg_words [3] = '{2, 1, 8};
    int cfg_cmax  [3] = '{65535, 15, 65535};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic [31:0] cnt;
    } exp_t;
    exp_t exp_q [3][$];
    exp_t mon_e;

    int          stall_n  [3];
    logic [31:0] exp_base [3];
    int          widx     [3];
    int          scnt     [3];
    int          resp_cnt [3];

    // Reference model: which block tags each way of each set holds.
    bit          m_v   [3][8][4];
    int unsigned m_t   [3][8][4];
    int          m_p   [3][8];
    int          m_cnt [3];

    function automatic logic [31:0] mem(input logic [31:0] a);
        logic [31:0] w;
        w = a & ~32'd3;
        return (w * 32'h9E3779B1) ^ 32'h0F1E2D3C ^ {w[15:0], w[31:16]};
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            m_cnt[d] = 0;
            for (int s = 0; s < 8; s++) begin
                m_p[d][s] = 0;
                for (int w = 0; w < 4; w++) begin
                    m_v[d][s][w] = 1'b0;
                    m_t[d][s][w] = 0;
                end
            end
        end
    endfunction

    function automatic void model_access(input int d, input logic [31:0] a,
                                         output bit hit, output logic [31:0] base);
        int unsigned blk, set, tg;
        int vic;
        blk  = a / 32'(4 * cfg_words[d]);
        set  = blk % 32'(cfg_sets[d]);
        tg   = blk / 32'(cfg_sets[d]);
        base = blk * 32'(4 * cfg_words[d]);
        hit  = 1'b0;
        for (int w = 0; w < cfg_ways[d]; w++)
            if (m_v[d][set][w] && m_t[d][set][w] == tg) hit = 1'b1;
        if (!hit) begin
            if (m_cnt[d] < cfg_cmax[d]) m_cnt[d]++;
            vic = -1;
            for (int w = 0; w < cfg_ways[d]; w++)
                if (!m_v[d][set][w] && vic < 0) vic = w;
            if (vic < 0) begin
                vic = m_p[d][set];
                m_p[d][set] = (m_p[d][set] + 1) % cfg_ways[d];
            end
            m_v[d][set][vic] = 1'b1;
            m_t[d][set][vic] = tg;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge CLK) cyc++;

    // Memory side: data is a fixed function of address, iwait held for stall_n cycles per word.
    always @(posedge CLK) begin
        #1;
        for (int g = 0; g < 3; g++) begin
            if (iREN[g]) begin
                check("iaddr", iaddr[g], exp_base[g] + 32'(4 * widx[g]));
                iload[g] = mem(iaddr[g]);
                if (scnt[g] < stall_n[g]) begin
                    iwait[g] = 1'b1;
                    scnt[g]++;
                end else begin
                    iwait[g] = 1'b0;
                    scnt[g]  = 0;
                    widx[g]++;
                end
            end else begin
                iwait[g] = 1'b0;
                iload[g] = 32'hDEAD_BEEF;
                scnt[g]  = 0;
                widx[g]  = 0;
            end
        end
    end

    always @(negedge CLK) begin
        for (int g = 0; g < 3; g++) begin
            if (ihit[g]) begin
                if (exp_q[g].size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL spurious_ihit inst %0d: ihit=1 at addr 0x%0h, required ihit=0", g, imemaddr[g]);
                end else begin
                    mon_e = exp_q[g].pop_front();
                    check("hit_cycle", cyc, mon_e.cyc);
                    check("imemload", imemload[g], mon_e.data);
                    check("miss_count", {16'd0, mc[g]}, mon_e.cnt);
                end
                resp_cnt[g]++;
            end
        end
    end

    // Called and returns just after a rising edge.
    task automatic access(input int d, input logic [31:0] a, input int s);
        bit          h;
        logic [31:0] base;
        exp_t        e;
        int          n0;
        int          t;
        model_access(d, a, h, base);
        stall_n[d]  = s;
        exp_base[d] = base;
        e.cyc  = cyc + (h ? 0 : cfg_words[d] * (1 + s) + 1);
        e.data = mem(a);
        e.cnt  = 32'(m_cnt[d]);
        exp_q[d].push_back(e);
        n0 = resp_cnt[d];
        imemaddr[d] = a;
        imemREN[d]  = 1'b1;
        t = 0;
        while (resp_cnt[d] == n0 && t < 400) begin
            @(posedge CLK);
            #1;
            t++;
        end
        if (resp_cnt[d] == n0) begin
            n_tests++;
            n_fail++;
            $display("FAIL access_timeout inst %0d: no ihit for addr 0x%0h within %0d cycles", d, a, t);
            exp_q[d].delete();
            imemREN[d] = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int g = 0; g < 3; g++) begin
            check({tag, "_ihit"}, {31'd0, ihit[g]}, 32'd0);
            check({tag, "_iREN"}, {31'd0, iREN[g]}, 32'd0);
            check({tag, "_iaddr"}, iaddr[g], 32'd0);
            check({tag, "_miss_count"}, {16'd0, mc[g]}, 32'd0);
        end
    endtask

    function automatic logic [31:0] rand_addr(input int d);
        logic [31:0] a;
        int span;
        span = cfg_sets[d] * (cfg_ways[d] + 2) * cfg_words[d];
        a = (32'($urandom_range(0, span - 1)) << 2) | 32'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
        return a;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        nRST  = 1'b0;
        flush = 1'b0;
        for (int g = 0; g < 3; g++) begin
            imemREN[g]  = 1'b0;
            imemaddr[g] = '0;
            stall_n[g]  = 0;
            exp_base[g] = '0;
            resp_cnt[g] = 0;
        end
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        nRST = 1'b1;
        check_reset_outputs("reset");

        // Cold miss then same-block hit
        access(0, 32'h100, 0);
        access(0, 32'h104, 0);
        // Wait states on every word
        access(0, 32'h200, 3);
        access(0, 32'h204, 1);

        // Replacement in set 0
        flush = 1'b1;
        step();
        flush = 1'b0;
        model_reset();
        check("flush_miss_count", {16'd0, mc[0]}, 32'd0);
        access(0, 32'h000, 0);
        access(0, 32'h040, 0);
        access(0, 32'h080, 0);
        access(0, 32'h044, 0);
        access(0, 32'h000, 1);
        check("repl_miss_count", {16'd0, mc[0]}, 32'd4);
        access(0, 32'h084, 0);
        access(0, 32'h040, 0);

        // Flush after the first word of a fill
        access(0, 32'h100, 0);
        imemaddr[0] = 32'h300;
        exp_base[0] = 32'h300;
        stall_n[0]  = 0;
        imemREN[0]  = 1'b1;
        step();
        step();
        flush = 1'b1;
        step();
        flush      = 1'b0;
        imemREN[0] = 1'b0;
        model_reset();
        check("flushfill_iREN", {31'd0, iREN[0]}, 32'd0);
        check("flushfill_miss_count", {16'd0, mc[0]}, 32'd0);
        access(0, 32'h100, 0);
        access(0, 32'h300, 2);

        // Reset in the middle of a fill
        imemaddr[0] = 32'h500;
        exp_base[0] = 32'h500;
        stall_n[0]  = 1;
        imemREN[0]  = 1'b1;
        step();
        nRST = 1'b0;
        step();
        nRST       = 1'b1;
        imemREN[0] = 1'b0;
        model_reset();
        check_reset_outputs("midreset");
        access(0, 32'h500, 0);

        // Randomized streams on all three configurations
        for (int i = 0; i < 150; i++) access(0, rand_addr(0), $urandom_range(0, 2));
        imemREN[0] = 1'b0;
        for (int i = 0; i < 100; i++) access(1, rand_addr(1), $urandom_range(0, 2));
        imemREN[1] = 1'b0;
        check("sat_miss_count", {16'd0, mc[1]}, 32'd15);
        for (int i = 0; i < 60; i++) access(2, rand_addr(2), $urandom_range(0, 1));
        imemREN[2] = 1'b0;

        repeat (4) step();
        for (int g = 0; g < 3; g++) check("scoreboard_drained", 32'(exp_q[g].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
